// File: rtl/buffered_decoder.sv
// buffered_decoder: circular instruction queue feeding a registered RV32I decode stage.
// Define DEC_ILLEGAL_TRAP_EN to add the registered dis_illegal_out flag.
module buffered_decoder #(
    parameter int IQ_DEPTH = 8,
    parameter int IQ_AW    = 3,
    parameter int OP_WIDTH = 6
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rob_rollback_in,
    input  logic                fet_valid_in,
    input  logic [31:0]         fet_inst_in,
    input  logic [31:0]         fet_pc_in,
    input  logic [31:0]         fet_predict_pc_in,
    output logic                fet_ready_out,
    output logic                dis_valid_out,
    input  logic                dis_ready_in,
    output logic [OP_WIDTH-1:0] dis_op_out,
    output logic [31:0]         dis_imm_out,
    output logic [4:0]          dis_rs1_out,
    output logic [4:0]          dis_rs2_out,
    output logic [4:0]          dis_rd_out,
    output logic                dis_occupy_rd_out,
    output logic [1:0]          dis_to_lsb_out,
    output logic [2:0]          dis_lsb_goal_out,
    output logic [31:0]         dis_pc_out,
    output logic [31:0]         dis_predict_pc_out,
    output logic [31:0]         dis_inst_out,
    output logic [IQ_AW:0]      iq_count_out
`ifdef DEC_ILLEGAL_TRAP_EN
    ,
    output logic                dis_illegal_out
`endif
);

    localparam logic [OP_WIDTH-1:0] OP_NOP = 0, OP_LUI = 1, OP_AUIPC = 2, OP_JAL = 3;
    localparam logic [OP_WIDTH-1:0] OP_JALR = 4, OP_BEQ = 5, OP_BNE = 6, OP_BLT = 7;
    localparam logic [OP_WIDTH-1:0] OP_BGE = 8, OP_BLTU = 9, OP_BGEU = 10, OP_LB = 11;
    localparam logic [OP_WIDTH-1:0] OP_LH = 12, OP_LW = 13, OP_LBU = 14, OP_LHU = 15;
    localparam logic [OP_WIDTH-1:0] OP_SB = 16, OP_SH = 17, OP_SW = 18, OP_ADDI = 19;
    localparam logic [OP_WIDTH-1:0] OP_SLTI = 20, OP_SLTIU = 21, OP_XORI = 22, OP_ORI = 23;
    localparam logic [OP_WIDTH-1:0] OP_ANDI = 24, OP_SLLI = 25, OP_SRLI = 26, OP_SRAI = 27;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 28, OP_SUB = 29, OP_SLL = 30, OP_SLT = 31;
    localparam logic [OP_WIDTH-1:0] OP_SLTU = 32, OP_XOR = 33, OP_SRL = 34, OP_SRA = 35;
    localparam logic [OP_WIDTH-1:0] OP_OR = 36, OP_AND = 37;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] ppc;
    } ent_t;

    typedef struct packed {
        logic                valid;
        logic [OP_WIDTH-1:0] op;
        logic [31:0]         imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                occ;
        logic [1:0]          lsb;
        logic [2:0]          goal;
`ifdef DEC_ILLEGAL_TRAP_EN
        logic                ill;
`endif
        logic [31:0]         pc;
        logic [31:0]         ppc;
        logic [31:0]         inst;
    } dis_t;

    ent_t                iq_q [IQ_DEPTH];
    logic [IQ_AW:0]      head_q, head_d, tail_q, tail_d;
    dis_t                dis_q, dis_d;
    ent_t                h_ent;
    logic [31:0]         hi, imm_i;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic                full, empty, push, load, r_ok;
    logic [OP_WIDTH-1:0] dec_op;
    logic [31:0]         dec_imm;

    // Wrap bit distinguishes full from empty when the addresses coincide
    assign empty = (head_q == tail_q);
    assign full  = (head_q[IQ_AW-1:0] == tail_q[IQ_AW-1:0]) &&
                   (head_q[IQ_AW] != tail_q[IQ_AW]);
    assign fet_ready_out = !full;
    assign iq_count_out  = tail_q - head_q;
    assign push = fet_valid_in && !full;
    assign load = !empty && (!dis_q.valid || dis_ready_in);

    assign h_ent = iq_q[head_q[IQ_AW-1:0]];
    assign hi    = h_ent.inst;
    assign f3    = hi[14:12];
    assign f7    = hi[31:25];
    assign imm_i = {{20{hi[31]}}, hi[31:20]};
    assign r_ok  = (f7 == 7'b0) ||
                   (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));

    always_comb begin
        dec_op  = OP_NOP;
        dec_imm = '0;
        unique case (hi[6:0])
            7'b0110111: begin dec_op = OP_LUI; dec_imm = {hi[31:12], 12'b0}; end
            7'b0010111: begin dec_op = OP_AUIPC; dec_imm = {hi[31:12], 12'b0}; end
            7'b1101111: begin
                dec_op  = OP_JAL;
                dec_imm = {{12{hi[31]}}, hi[19:12], hi[20], hi[30:21], 1'b0};
            end
            7'b1100111: begin
                dec_imm = imm_i;
                if (f3 == 3'b000) dec_op = OP_JALR;
            end
            7'b1100011: begin
                dec_imm = {{20{hi[31]}}, hi[7], hi[30:25], hi[11:8], 1'b0};
                unique case (f3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    3'b110:  dec_op = OP_BLTU;
                    3'b111:  dec_op = OP_BGEU;
                    default: dec_op = OP_NOP;
                endcase
            end
            7'b0000011: begin
                dec_imm = imm_i;
                unique case (f3)
                    3'b000:  dec_op = OP_LB;
                    3'b001:  dec_op = OP_LH;
                    3'b010:  dec_op = OP_LW;
                    3'b100:  dec_op = OP_LBU;
                    3'b101:  dec_op = OP_LHU;
                    default: dec_op = OP_NOP;
                endcase
            end
            7'b0100011: begin
                dec_imm = {{20{hi[31]}}, hi[31:25], hi[11:7]};
                unique case (f3)
                    3'b000:  dec_op = OP_SB;
                    3'b001:  dec_op = OP_SH;
                    3'b010:  dec_op = OP_SW;
                    default: dec_op = OP_NOP;
                endcase
            end
            7'b0010011: begin
                dec_imm = imm_i;
                unique case (f3)
                    3'b000: dec_op = OP_ADDI;
                    3'b010: dec_op = OP_SLTI;
                    3'b011: dec_op = OP_SLTIU;
                    3'b100: dec_op = OP_XORI;
                    3'b110: dec_op = OP_ORI;
                    3'b111: dec_op = OP_ANDI;
                    3'b001: if (f7 == 7'b0) dec_op = OP_SLLI;
                    3'b101: begin
                        if (f7 == 7'b0) dec_op = OP_SRLI;
                        else if (f7 == 7'b0100000) dec_op = OP_SRAI;
                    end
                endcase
            end
            7'b0110011: begin
                if (r_ok) begin
                    unique case (f3)
                        3'b000: dec_op = hi[30] ? OP_SUB : OP_ADD;
                        3'b001: dec_op = OP_SLL;
                        3'b010: dec_op = OP_SLT;
                        3'b011: dec_op = OP_SLTU;
                        3'b100: dec_op = OP_XOR;
                        3'b101: dec_op = hi[30] ? OP_SRA : OP_SRL;
                        3'b110: dec_op = OP_OR;
                        3'b111: dec_op = OP_AND;
                    endcase
                end
            end
            default: dec_op = OP_NOP;
        endcase
        // Illegal encodings still flow to the ROB, but carry no payload
        if (dec_op == OP_NOP) dec_imm = '0;
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (rob_rollback_in) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (load) head_d = head_q + 1'b1;
        end
    end

    always_comb begin
        dis_d = dis_q;
        if (rob_rollback_in) begin
            dis_d    = '0;
            dis_d.op = OP_NOP;
        end else if (load) begin
            dis_d.valid = 1'b1;
            dis_d.op    = dec_op;
            dis_d.imm   = dec_imm;
            dis_d.rs1   = hi[19:15];
            dis_d.rs2   = hi[24:20];
            dis_d.rd    = hi[11:7];
            dis_d.occ   = (dec_op != OP_NOP) && (hi[11:7] != 5'd0) &&
                          !(dec_op >= OP_BEQ && dec_op <= OP_BGEU) &&
                          !(dec_op >= OP_SB && dec_op <= OP_SW);
            dis_d.lsb   = (dec_op >= OP_LB && dec_op <= OP_LHU) ? 2'b10 :
                          (dec_op >= OP_SB && dec_op <= OP_SW)  ? 2'b11 : 2'b00;
            dis_d.goal  = (dec_op == OP_LB || dec_op == OP_LBU || dec_op == OP_SB) ? 3'b001 :
                          (dec_op == OP_LH || dec_op == OP_LHU || dec_op == OP_SH) ? 3'b010 :
                          (dec_op == OP_LW || dec_op == OP_SW) ? 3'b100 : 3'b000;
`ifdef DEC_ILLEGAL_TRAP_EN
            dis_d.ill   = (dec_op == OP_NOP);
`endif
            dis_d.pc    = h_ent.pc;
            dis_d.ppc   = h_ent.ppc;
            dis_d.inst  = hi;
        end else if (dis_ready_in) begin
            dis_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !rob_rollback_in)
            iq_q[tail_q[IQ_AW-1:0]] <= '{inst: fet_inst_in, pc: fet_pc_in, ppc: fet_predict_pc_in};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q <= '0;
            tail_q <= '0;
            dis_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            dis_q  <= dis_d;
        end
    end

    assign dis_valid_out      = dis_q.valid;
    assign dis_op_out         = dis_q.op;
    assign dis_imm_out        = dis_q.imm;
    assign dis_rs1_out        = dis_q.rs1;
    assign dis_rs2_out        = dis_q.rs2;
    assign dis_rd_out         = dis_q.rd;
    assign dis_occupy_rd_out  = dis_q.occ;
    assign dis_to_lsb_out     = dis_q.lsb;
    assign dis_lsb_goal_out   = dis_q.goal;
    assign dis_pc_out         = dis_q.pc;
    assign dis_predict_pc_out = dis_q.ppc;
    assign dis_inst_out       = dis_q.inst;
`ifdef DEC_ILLEGAL_TRAP_EN
    assign dis_illegal_out    = dis_q.ill;
`endif

endmodule

// File: tb/tb_buffered_decoder.sv
// tb_buffered_decoder: scoreboard bench for the queued RV32I decode stage.
// Expected decode fields come from a hand-written instruction table.
module tb_buffered_decoder;

    localparam logic [5:0] OP_NOP = 0, OP_LUI = 1, OP_JAL = 3, OP_BEQ = 5;
    localparam logic [5:0] OP_LW = 13, OP_LBU = 14, OP_SW = 18, OP_ADDI = 19, OP_SUB = 29;
    localparam int NENT = 11;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        occ;
        logic [1:0]  lsb;
        logic [2:0]  goal;
        logic        ill;
        logic [31:0] pc;
        logic [31:0] ppc;
        logic [31:0] inst;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rollback = 1'b0;
    logic        fet_valid = 1'b0;
    logic [31:0] fet_inst = '0, fet_pc = '0, fet_ppc = '0;
    logic        fet_ready;
    logic        dis_valid;
    logic        dis_ready = 1'b0;
    logic [5:0]  dis_op;
    logic [31:0] dis_imm, dis_pc, dis_ppc, dis_inst;
    logic [4:0]  dis_rs1, dis_rs2, dis_rd;
    logic        dis_occ;
    logic [1:0]  dis_lsb;
    logic [2:0]  dis_goal;
    logic [3:0]  iq_count;
    logic        dis_ill;

    rec_t sb[$];
    rec_t cur = '0;
    int   total = 0;
    int   passed = 0;
    int   outs = 0;

    buffered_decoder dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .rob_rollback_in(rollback),
        .fet_valid_in(fet_valid),
        .fet_inst_in(fet_inst),
        .fet_pc_in(fet_pc),
        .fet_predict_pc_in(fet_ppc),
        .fet_ready_out(fet_ready),
        .dis_valid_out(dis_valid),
        .dis_ready_in(dis_ready),
        .dis_op_out(dis_op),
        .dis_imm_out(dis_imm),
        .dis_rs1_out(dis_rs1),
        .dis_rs2_out(dis_rs2),
        .dis_rd_out(dis_rd),
        .dis_occupy_rd_out(dis_occ),
        .dis_to_lsb_out(dis_lsb),
        .dis_lsb_goal_out(dis_goal),
        .dis_pc_out(dis_pc),
        .dis_predict_pc_out(dis_ppc),
        .dis_inst_out(dis_inst),
        .iq_count_out(iq_count)
`ifdef DEC_ILLEGAL_TRAP_EN
        ,
        .dis_illegal_out(dis_ill)
`endif
    );

`ifndef DEC_ILLEGAL_TRAP_EN
    assign dis_ill = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic rec_t exp_of(int i, logic [31:0] pc);
        rec_t r;
        r = '0;
        r.pc  = pc;
        r.ppc = pc ^ 32'h00A5_0000;
        case (i)
            0: begin r.inst = 32'h00500093; r.op = OP_ADDI; r.imm = 32'd5;
                     r.rs2 = 5; r.rd = 1; r.occ = 1'b1; end
            1: begin r.inst = 32'h0020A423; r.op = OP_SW; r.imm = 32'd8; r.rs1 = 1;
                     r.rs2 = 2; r.rd = 8; r.lsb = 2'b11; r.goal = 3'b100; end
            2: begin r.inst = 32'h123452B7; r.op = OP_LUI; r.imm = 32'h12345000;
                     r.rs1 = 8; r.rs2 = 3; r.rd = 5; r.occ = 1'b1; end
            3: begin r.inst = 32'h12345037; r.op = OP_LUI; r.imm = 32'h12345000;
                     r.rs1 = 8; r.rs2 = 3; r.rd = 0; end
            4: begin r.inst = 32'h00000000; r.op = OP_NOP; r.ill = 1'b1; end
            5: begin r.inst = 32'h402081B3; r.op = OP_SUB; r.rs1 = 1; r.rs2 = 2;
                     r.rd = 3; r.occ = 1'b1; end
            6: begin r.inst = 32'h00208863; r.op = OP_BEQ; r.imm = 32'd16; r.rs1 = 1;
                     r.rs2 = 2; r.rd = 16; end
            7: begin r.inst = 32'hFFC0A203; r.op = OP_LW; r.imm = 32'hFFFFFFFC; r.rs1 = 1;
                     r.rs2 = 28; r.rd = 4; r.occ = 1'b1; r.lsb = 2'b10; r.goal = 3'b100; end
            8: begin r.inst = 32'h008000EF; r.op = OP_JAL; r.imm = 32'd8; r.rs2 = 8;
                     r.rd = 1; r.occ = 1'b1; end
            9: begin r.inst = 32'h00314283; r.op = OP_LBU; r.imm = 32'd3; r.rs1 = 2;
                     r.rs2 = 3; r.rd = 5; r.occ = 1'b1; r.lsb = 2'b10; r.goal = 3'b001; end
            default: begin r.inst = 32'h02208033; r.op = OP_NOP; r.rs1 = 1; r.rs2 = 2;
                     r.ill = 1'b1; end
        endcase
`ifndef DEC_ILLEGAL_TRAP_EN
        r.ill = 1'b0;
`endif
        return r;
    endfunction

    task automatic offer(int i, logic [31:0] pc);
        cur       = exp_of(i, pc);
        fet_inst  = cur.inst;
        fet_pc    = cur.pc;
        fet_ppc   = cur.ppc;
        fet_valid = 1'b1;
    endtask

    // Scoreboard: push on accepted fetch, pop on consumed dispatch
    always @(negedge clk) begin : mon
        rec_t a, e;
        if (!rst_n || rollback) begin
            sb.delete();
        end else begin
            if (dis_valid && dis_ready) begin
                outs++;
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_output actual_pc=%h required=none", dis_pc);
                end else begin
                    e = sb.pop_front();
                    a = '{op: dis_op, imm: dis_imm, rs1: dis_rs1, rs2: dis_rs2, rd: dis_rd,
                          occ: dis_occ, lsb: dis_lsb, goal: dis_goal, ill: dis_ill,
                          pc: dis_pc, ppc: dis_ppc, inst: dis_inst};
                    if (a !== e)
                        $display("FAIL decode_out actual=%h required=%h", a, e);
                    else
                        passed++;
                end
            end
            if (fet_valid && fet_ready) sb.push_back(cur);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dis_valid !== 1'b0) $display("FAIL reset_valid actual=%b required=0", dis_valid);
        else passed++;
        total++;
        if (dis_op !== OP_NOP) $display("FAIL reset_op actual=%0d required=%0d", dis_op, OP_NOP);
        else passed++;
        total++;
        if (iq_count !== 4'd0) $display("FAIL reset_count actual=%0d required=0", iq_count);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (fet_ready !== 1'b1) $display("FAIL reset_ready actual=%b required=1", fet_ready);
        else passed++;
    endtask

    task automatic test_decode();
        dis_ready = 1'b1;
        for (int i = 0; i < NENT; i++) begin
            offer(i, 32'h1000 + 32'(i * 4));
            @(posedge clk);
            #1;
            fet_valid = 1'b0;
            total++;
            if (dis_valid !== 1'b0 || iq_count !== 4'd1)
                $display("FAIL latency_edge_n entry=%0d actual=%b/%0d required=0/1",
                         i, dis_valid, iq_count);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (dis_valid !== 1'b1 || iq_count !== 4'd0)
                $display("FAIL latency_edge_n1 entry=%0d actual=%b/%0d required=1/0",
                         i, dis_valid, iq_count);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (dis_valid !== 1'b0) $display("FAIL valid_clear entry=%0d actual=%b required=0", i, dis_valid);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int o0;
        dis_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            offer(i, 32'h2000 + 32'(i * 4));
            @(posedge clk);
            #1;
        end
        fet_valid = 1'b0;
        total++;
        if (iq_count !== 4'd8 || fet_ready !== 1'b0)
            $display("FAIL full_state actual=%0d/%b required=8/0", iq_count, fet_ready);
        else passed++;
        total++;
        if (sb.size() != 9) $display("FAIL accepted_count actual=%0d required=9", sb.size());
        else passed++;
        total++;
        if (dis_valid !== 1'b1 || dis_pc !== 32'h2000)
            $display("FAIL held_output actual=%b/%h required=1/00002000", dis_valid, dis_pc);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dis_pc !== 32'h2000 || dis_inst !== 32'h00500093)
            $display("FAIL stall_stable actual=%h/%h required=00002000/00500093", dis_pc, dis_inst);
        else passed++;
        o0 = outs;
        dis_ready = 1'b1;
        #1;
        total++;
        if (fet_ready !== 1'b0) $display("FAIL ready_full_deq actual=%b required=0", fet_ready);
        else passed++;
        for (int k = 0; k < 9; k++) begin
            total++;
            if (dis_valid !== 1'b1) $display("FAIL drain_gap cycle=%0d actual=%b required=1", k, dis_valid);
            else passed++;
            @(posedge clk);
            #1;
        end
        total++;
        if (dis_valid !== 1'b0 || outs - o0 != 9)
            $display("FAIL drain_end actual=%b/%0d required=0/9", dis_valid, outs - o0);
        else passed++;
    endtask

    task automatic test_rollback();
        dis_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(i + 5, 32'h3000 + 32'(i * 4));
            @(posedge clk);
            #1;
        end
        fet_valid = 1'b0;
        total++;
        if (iq_count !== 4'd4 || dis_valid !== 1'b1)
            $display("FAIL pre_rollback actual=%0d/%b required=4/1", iq_count, dis_valid);
        else passed++;
        rollback = 1'b1;
        offer(0, 32'h3100);
        @(posedge clk);
        #1;
        rollback  = 1'b0;
        fet_valid = 1'b0;
        total++;
        if (iq_count !== 4'd0 || dis_valid !== 1'b0 || dis_op !== OP_NOP || fet_ready !== 1'b1)
            $display("FAIL rollback_state actual=%0d/%b/%0d/%b required=0/0/0/1",
                     iq_count, dis_valid, dis_op, fet_ready);
        else passed++;
        dis_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (dis_valid !== 1'b0) $display("FAIL rollback_drop cycle=%0d actual=%b required=0", k, dis_valid);
            else passed++;
        end
        offer(2, 32'h3200);
        @(posedge clk);
        #1;
        fet_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (dis_valid !== 1'b1 || dis_pc !== 32'h3200)
            $display("FAIL post_rollback actual=%b/%h required=1/00003200", dis_valid, dis_pc);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        dis_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(i, 32'h4000 + 32'(i * 4));
            @(posedge clk);
            #1;
        end
        fet_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dis_valid !== 1'b0 || iq_count !== 4'd0 || dis_op !== OP_NOP ||
            dis_pc !== 32'd0 || dis_imm !== 32'd0 || dis_inst !== 32'd0)
            $display("FAIL mid_reset actual=%b/%0d/%0d/%h/%h required=0/0/0/0/0",
                     dis_valid, iq_count, dis_op, dis_pc, dis_imm);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (fet_ready !== 1'b1 || dis_valid !== 1'b0)
            $display("FAIL mid_reset_release actual=%b/%b required=1/0", fet_ready, dis_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        dis_ready = 1'b1;
        for (int i = 0; i < NENT; i++) begin
            offer(i, 32'h5000 + 32'(i * 4));
            @(posedge clk);
            #1;
            if (i > 0) begin
                total++;
                if (dis_valid !== 1'b1) $display("FAIL b2b_valid cycle=%0d actual=%b required=1", i, dis_valid);
                else passed++;
            end
        end
        fet_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        total++;
        if (dis_valid !== 1'b0 || iq_count !== 4'd0)
            $display("FAIL b2b_end actual=%b/%0d required=0/0", dis_valid, iq_count);
        else passed++;
    endtask

    task automatic test_random();
        int budget;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(1, 0) == 1) offer($urandom_range(NENT - 1, 0), 32'h8000 + 32'(c * 4));
            else fet_valid = 1'b0;
            dis_ready = ($urandom_range(3, 0) != 0);
            @(posedge clk);
            #1;
        end
        fet_valid = 1'b0;
        dis_ready = 1'b1;
        budget = 0;
        while ((sb.size() != 0 || dis_valid) && budget < 30) begin
            @(posedge clk);
            #1;
            budget++;
        end
        total++;
        if (sb.size() != 0 || dis_valid !== 1'b0)
            $display("FAIL random_drain actual=%0d_left required=0", sb.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_rollback();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
